// File: rtl/oc8051_irq_ctrl_pkg.sv
// Shared constants and helpers for the oc8051 interrupt controller:
// SFR addresses, reset values, vectors and interrupt source ordering.
package oc8051_irq_ctrl_pkg;

   // SFR byte addresses (all bit-addressable: bit address = byte address + bit)
   localparam logic [7:0] OC8051_SFR_IE   = 8'hA8;
   localparam logic [7:0] OC8051_SFR_IP   = 8'hB8;
   localparam logic [7:0] OC8051_SFR_TCON = 8'h88;

   // Reset values
   localparam logic [7:0] OC8051_RST_IE   = 8'h00;
   localparam logic [7:0] OC8051_RST_IP   = 8'h00;
   localparam logic [7:0] OC8051_RST_TCON = 8'h00;

   // Storage mask for IE/IP (bits 6:5 always read as zero)
   localparam logic [7:0] OC8051_IEIP_MASK = 8'h9F;

   // Interrupt vectors
   localparam logic [7:0] OC8051_INT_VEC_X0 = 8'h03;
   localparam logic [7:0] OC8051_INT_VEC_T0 = 8'h0B;
   localparam logic [7:0] OC8051_INT_VEC_X1 = 8'h13;
   localparam logic [7:0] OC8051_INT_VEC_T1 = 8'h1B;
   localparam logic [7:0] OC8051_INT_VEC_S  = 8'h23;

   // Source index order; also the fixed in-level priority (lowest index wins)
   // and the matching bit position in IE/IP.
   localparam int unsigned NUM_SRC = 5;
   localparam logic [2:0] SRC_IE0 = 3'd0;
   localparam logic [2:0] SRC_TF0 = 3'd1;
   localparam logic [2:0] SRC_IE1 = 3'd2;
   localparam logic [2:0] SRC_TF1 = 3'd3;
   localparam logic [2:0] SRC_SER = 3'd4;

   typedef enum logic {
      ST_IDLE,
      ST_REQ
   } irq_state_e;

   // Vector address for a source index
   function automatic logic [7:0] src_vector(input logic [2:0] idx);
      logic [7:0] v;
      case (idx)
         SRC_IE0: v = OC8051_INT_VEC_X0;
         SRC_TF0: v = OC8051_INT_VEC_T0;
         SRC_IE1: v = OC8051_INT_VEC_X1;
         SRC_TF1: v = OC8051_INT_VEC_T1;
         SRC_SER: v = OC8051_INT_VEC_S;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Software view of an SFR after a byte or bit write
   function automatic logic [7:0] sfr_write(input logic [7:0] cur,
                                            input logic       byte_hit,
                                            input logic       bit_hit,
                                            input logic [2:0] sel,
                                            input logic [7:0] din,
                                            input logic       bin);
      logic [7:0] v;
      v = cur;
      if (byte_hit)
         v = din;
      else if (bit_hit)
         v[sel] = bin;
      return v;
   endfunction

   // Mask of SFR bits touched by a byte or bit write
   function automatic logic [7:0] sfr_hit_mask(input logic       byte_hit,
                                               input logic       bit_hit,
                                               input logic [2:0] sel);
      logic [7:0] m;
      m = '0;
      if (byte_hit)
         m = '1;
      else if (bit_hit)
         m[sel] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/oc8051_int_sync.sv
// External interrupt pin conditioning: two-flop synchroniser followed by a
// third flop used to detect falling edges. Flops idle high (pin inactive).
module oc8051_int_sync
   import oc8051_irq_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pin_n,
   output logic sync_n,
   output logic fall
);

   logic s1, s2, s3;

   // Synchroniser chain plus edge-detect delay
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= pin_n;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync_n = s2;
   assign fall   = s3 & ~s2;

endmodule

// File: rtl/oc8051_irq_ctrl.sv
// oc8051 interrupt controller and TCON owner: IE/IP/TCON SFRs, source flag
// latching, two-level arbitration, in-service tracking and the request FSM.
module oc8051_irq_ctrl
   import oc8051_irq_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] wr_addr,
   input  logic [7:0] rd_addr,
   input  logic [7:0] data_in,
   input  logic       bit_in,
   input  logic       wr,
   input  logic       wr_bit,
   input  logic       int0_n,
   input  logic       int1_n,
   input  logic       tf0,
   input  logic       tf1,
   input  logic       uart_int,
   input  logic       int_ack,
   input  logic       reti,
   output logic       intr,
   output logic [7:0] int_vec,
   output logic       tr0,
   output logic       tr1,
   output logic [7:0] data_out
);

   logic [7:0] ie, ip, tcon;
   logic [7:0] tcon_sw, tcon_hit, tcon_nxt;
   logic       int0_sync_n, int0_fall, int1_sync_n, int1_fall;
   logic       tf0_d, tf1_d, tf0_rise, tf1_rise;
   logic       wr_byte, wr_bitw;
   logic       ie_byte_hit, ie_bit_hit, ip_byte_hit, ip_bit_hit;
   logic       tcon_byte_hit, tcon_bit_hit;
   logic [4:0] src_flag, pend, pend_hi, ack_src;
   logic [2:0] win_idx;
   logic       win_valid, win_hi, win_elig;
   logic [1:0] isr, isr_eff;
   logic [2:0] req_src;
   logic       req_lvl;
   logic       ack_now;
   irq_state_e state;

   oc8051_int_sync u_sync0 (
      .clk    (clk),
      .rst    (rst),
      .pin_n  (int0_n),
      .sync_n (int0_sync_n),
      .fall   (int0_fall)
   );

   oc8051_int_sync u_sync1 (
      .clk    (clk),
      .rst    (rst),
      .pin_n  (int1_n),
      .sync_n (int1_sync_n),
      .fall   (int1_fall)
   );

   assign wr_byte       = wr & ~wr_bit;
   assign wr_bitw       = wr & wr_bit;
   assign ie_byte_hit   = wr_byte && (wr_addr == OC8051_SFR_IE);
   assign ip_byte_hit   = wr_byte && (wr_addr == OC8051_SFR_IP);
   assign tcon_byte_hit = wr_byte && (wr_addr == OC8051_SFR_TCON);
   assign ie_bit_hit    = wr_bitw && (wr_addr[7:3] == OC8051_SFR_IE[7:3]);
   assign ip_bit_hit    = wr_bitw && (wr_addr[7:3] == OC8051_SFR_IP[7:3]);
   assign tcon_bit_hit  = wr_bitw && (wr_addr[7:3] == OC8051_SFR_TCON[7:3]);

   assign tf0_rise = tf0 & ~tf0_d;
   assign tf1_rise = tf1 & ~tf1_d;

   assign ack_now = (state == ST_REQ) && int_ack;
   assign ack_src = ack_now ? (5'b00001 << req_src) : 5'b00000;

   assign tr0 = tcon[4];
   assign tr1 = tcon[6];

   // Timer overflow delay flops for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tf0_d <= 1'b0;
         tf1_d <= 1'b0;
      end else begin
         tf0_d <= tf0;
         tf1_d <= tf1;
      end
   end

   // IE and IP registers; unimplemented bits are forced to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ie <= OC8051_RST_IE;
         ip <= OC8051_RST_IP;
      end else begin
         ie <= sfr_write(ie, ie_byte_hit, ie_bit_hit, wr_addr[2:0], data_in, bit_in)
               & OC8051_IEIP_MASK;
         ip <= sfr_write(ip, ip_byte_hit, ip_bit_hit, wr_addr[2:0], data_in, bit_in)
               & OC8051_IEIP_MASK;
      end
   end

   // TCON next state: software write beats hardware set, which beats ack clear
   always_comb begin
      tcon_sw  = sfr_write(tcon, tcon_byte_hit, tcon_bit_hit, wr_addr[2:0], data_in, bit_in);
      tcon_hit = sfr_hit_mask(tcon_byte_hit, tcon_bit_hit, wr_addr[2:0]);
      tcon_nxt = tcon_sw;
      // IE0: level mode follows the pin, edge mode latches falling edges
      if (!tcon_hit[1]) begin
         if (!tcon[0])
            tcon_nxt[1] = ~int0_sync_n;
         else if (int0_fall)
            tcon_nxt[1] = 1'b1;
         else if (ack_src[SRC_IE0])
            tcon_nxt[1] = 1'b0;
      end
      // IE1
      if (!tcon_hit[3]) begin
         if (!tcon[2])
            tcon_nxt[3] = ~int1_sync_n;
         else if (int1_fall)
            tcon_nxt[3] = 1'b1;
         else if (ack_src[SRC_IE1])
            tcon_nxt[3] = 1'b0;
      end
      // TF0
      if (!tcon_hit[5]) begin
         if (tf0_rise)
            tcon_nxt[5] = 1'b1;
         else if (ack_src[SRC_TF0])
            tcon_nxt[5] = 1'b0;
      end
      // TF1
      if (!tcon_hit[7]) begin
         if (tf1_rise)
            tcon_nxt[7] = 1'b1;
         else if (ack_src[SRC_TF1])
            tcon_nxt[7] = 1'b0;
      end
   end

   // TCON register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tcon <= OC8051_RST_TCON;
      else
         tcon <= tcon_nxt;
   end

   // Arbitration: highest pending IP level, then fixed index order; the
   // in-service level seen here already reflects a same-cycle reti.
   always_comb begin
      src_flag  = {uart_int, tcon[7], tcon[3], tcon[5], tcon[1]};
      pend      = src_flag & ie[4:0] & {5{ie[7]}};
      pend_hi   = pend & ip[4:0];
      win_valid = |pend;
      win_hi    = |pend_hi;
      win_idx   = '0;
      for (int unsigned i = NUM_SRC; i > 0; i--) begin
         if (win_hi ? pend_hi[i-1] : pend[i-1])
            win_idx = 3'(i - 1);
      end
      isr_eff = isr;
      if (reti) begin
         if (isr[1])
            isr_eff[1] = 1'b0;
         else
            isr_eff[0] = 1'b0;
      end
      win_elig = win_valid & ~isr_eff[1] & (win_hi | ~isr_eff[0]);
   end

   // In-service register: reti clears the top level, ack marks the taken level
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         isr <= '0;
      else if (ack_now)
         isr <= isr_eff | (req_lvl ? 2'b10 : 2'b01);
      else
         isr <= isr_eff;
   end

   // Request FSM with registered intr/int_vec and the source being offered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         intr    <= 1'b0;
         int_vec <= '0;
         req_src <= '0;
         req_lvl <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_elig) begin
                  state   <= ST_REQ;
                  intr    <= 1'b1;
                  int_vec <= src_vector(win_idx);
                  req_src <= win_idx;
                  req_lvl <= win_hi;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  state <= ST_IDLE;
                  intr  <= 1'b0;
               end else if (win_elig) begin
                  int_vec <= src_vector(win_idx);
                  req_src <= win_idx;
                  req_lvl <= win_hi;
               end else begin
                  state <= ST_IDLE;
                  intr  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               intr  <= 1'b0;
            end
         endcase
      end
   end

   // Registered SFR read with write-through bypass
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         data_out <= '0;
      else if (wr_byte && (wr_addr == rd_addr))
         data_out <= data_in;
      else begin
         case (rd_addr)
            OC8051_SFR_IE:   data_out <= ie;
            OC8051_SFR_IP:   data_out <= ip;
            OC8051_SFR_TCON: data_out <= tcon;
            default:         data_out <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_oc8051_irq_ctrl.sv
// Directed self-checking bench for oc8051_irq_ctrl.
module tb_oc8051_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wr_addr = '0, rd_addr = '0, data_in = '0;
   logic       bit_in = 1'b0, wr = 1'b0, wr_bit = 1'b0;
   logic       int0_n = 1'b1, int1_n = 1'b1, tf0 = 1'b0, tf1 = 1'b0;
   logic       uart_int = 1'b0, int_ack = 1'b0, reti = 1'b0;
   logic       intr, tr0, tr1;
   logic [7:0] int_vec, data_out;

   int n_cmp = 0;
   int n_err = 0;

   oc8051_irq_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .wr_addr  (wr_addr),
      .rd_addr  (rd_addr),
      .data_in  (data_in),
      .bit_in   (bit_in),
      .wr       (wr),
      .wr_bit   (wr_bit),
      .int0_n   (int0_n),
      .int1_n   (int1_n),
      .tf0      (tf0),
      .tf1      (tf1),
      .uart_int (uart_int),
      .int_ack  (int_ack),
      .reti     (reti),
      .intr     (intr),
      .int_vec  (int_vec),
      .tr0      (tr0),
      .tr1      (tr1),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr = 1'b0; wr_bit = 1'b0; int_ack = 1'b0; reti = 1'b0;
      int0_n = 1'b1; int1_n = 1'b1; tf0 = 1'b0; tf1 = 1'b0; uart_int = 1'b0;
      rd_addr = 8'h00;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic byte_wr(input logic [7:0] a, input logic [7:0] d);
      wr = 1'b1; wr_bit = 1'b0; wr_addr = a; data_in = d;
      cyc();
      wr = 1'b0;
   endtask

   task automatic bit_wr(input logic [7:0] a, input logic b);
      wr = 1'b1; wr_bit = 1'b1; wr_addr = a; bit_in = b;
      cyc();
      wr = 1'b0; wr_bit = 1'b0;
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      cyc();
      int_ack = 1'b0;
   endtask

   task automatic pulse_reti();
      reti = 1'b1;
      cyc();
      reti = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL reset_intr: got %b want 0", intr); end
      n_cmp++; if (int_vec !== 8'h00) begin n_err++; $display("FAIL reset_vec: got %h want 00", int_vec); end
      n_cmp++; if ({tr1, tr0} !== 2'b00) begin n_err++; $display("FAIL reset_tr: got %b want 00", {tr1, tr0}); end
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", data_out); end
      n_cmp++; if (dut.isr !== 2'b00) begin n_err++; $display("FAIL reset_isr: got %b want 00", dut.isr); end
   endtask

   task automatic test_edge_int0();
      int n;
      do_reset();
      rd_addr = 8'h88;
      byte_wr(8'h88, 8'h01);
      byte_wr(8'hA8, 8'h81);
      int0_n = 1'b0;
      cyc(); cyc();
      int0_n = 1'b1;
      n = 2;
      while (!intr && n < 12) begin cyc(); n++; end
      n_cmp++; if (intr !== 1'b1 || n != 4) begin n_err++; $display("FAIL int0_latency: intr %b after %0d cycles, want 1 after 4", intr, n); end
      n_cmp++; if (int_vec !== 8'h03) begin n_err++; $display("FAIL int0_vec: got %h want 03", int_vec); end
      n_cmp++; if (data_out !== 8'h03) begin n_err++; $display("FAIL int0_tcon: got %h want 03", data_out); end
      pulse_ack();
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL int0_ack_drop: got %b want 0", intr); end
      n_cmp++; if (dut.isr !== 2'b01) begin n_err++; $display("FAIL int0_isr: got %b want 01", dut.isr); end
      cyc();
      n_cmp++; if (data_out !== 8'h01) begin n_err++; $display("FAIL int0_clr: got %h want 01", data_out); end
      pulse_reti();
      n_cmp++; if (dut.isr !== 2'b00) begin n_err++; $display("FAIL int0_reti: got %b want 00", dut.isr); end
   endtask

   task automatic test_timer();
      do_reset();
      byte_wr(8'hA8, 8'h82);
      tf0 = 1'b1;
      cyc();
      tf0 = 1'b0;
      cyc();
      n_cmp++; if (intr !== 1'b1 || int_vec !== 8'h0B) begin n_err++; $display("FAIL tf0_req: got %b/%h want 1/0b", intr, int_vec); end
      bit_wr(8'h8C, 1'b1);
      n_cmp++; if (tr0 !== 1'b1 || tr1 !== 1'b0) begin n_err++; $display("FAIL tr0_bitwr: got tr1/tr0 %b%b want 01", tr1, tr0); end
      rd_addr = 8'h88;
      cyc();
      n_cmp++; if (data_out !== 8'h30) begin n_err++; $display("FAIL tcon_read: got %h want 30", data_out); end
      byte_wr(8'hA8, 8'h02);
      cyc();
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL ea_clear_drop: got %b want 0", intr); end
   endtask

   task automatic test_priority();
      do_reset();
      byte_wr(8'h88, 8'h01);
      byte_wr(8'hA8, 8'h89);
      int0_n = 1'b0;
      cyc(); cyc();
      int0_n = 1'b1; tf1 = 1'b1;
      cyc();
      tf1 = 1'b0;
      cyc();
      n_cmp++; if (intr !== 1'b1 || int_vec !== 8'h03) begin n_err++; $display("FAIL prio_first: got %b/%h want 1/03", intr, int_vec); end
      pulse_ack();
      cyc();
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL prio_blocked: got %b want 0", intr); end
      pulse_reti();
      n_cmp++; if (intr !== 1'b1 || int_vec !== 8'h1B) begin n_err++; $display("FAIL prio_second: got %b/%h want 1/1b", intr, int_vec); end
   endtask

   task automatic test_preempt();
      do_reset();
      byte_wr(8'hA8, 8'h92);
      byte_wr(8'hB8, 8'h10);
      tf0 = 1'b1;
      cyc();
      tf0 = 1'b0;
      cyc();
      pulse_ack();
      n_cmp++; if (dut.isr !== 2'b01) begin n_err++; $display("FAIL pre_isr_lo: got %b want 01", dut.isr); end
      uart_int = 1'b1;
      cyc();
      n_cmp++; if (intr !== 1'b1 || int_vec !== 8'h23) begin n_err++; $display("FAIL pre_ser: got %b/%h want 1/23", intr, int_vec); end
      pulse_ack();
      uart_int = 1'b0;
      n_cmp++; if (dut.isr !== 2'b11) begin n_err++; $display("FAIL pre_isr_both: got %b want 11", dut.isr); end
      byte_wr(8'hA8, 8'h96);
      int1_n = 1'b0;
      for (int i = 0; i < 6; i++) cyc();
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL pre_x1_block2: got %b want 0", intr); end
      pulse_reti();
      cyc();
      n_cmp++; if (intr !== 1'b0 || dut.isr !== 2'b01) begin n_err++; $display("FAIL pre_x1_block1: intr/isr %b/%b want 0/01", intr, dut.isr); end
      pulse_reti();
      n_cmp++; if (intr !== 1'b1 || int_vec !== 8'h13) begin n_err++; $display("FAIL pre_x1_go: got %b/%h want 1/13", intr, int_vec); end
   endtask

   task automatic test_level();
      int n;
      do_reset();
      byte_wr(8'hA8, 8'h84);
      int1_n = 1'b0;
      n = 0;
      while (!intr && n < 12) begin cyc(); n++; end
      n_cmp++; if (intr !== 1'b1 || n != 4 || int_vec !== 8'h13) begin n_err++; $display("FAIL lvl_req: intr %b vec %h after %0d, want 1 13 after 4", intr, int_vec, n); end
      pulse_ack();
      n_cmp++; if (intr !== 1'b0 || dut.tcon[3] !== 1'b1) begin n_err++; $display("FAIL lvl_ack: intr/ie1 %b/%b want 0/1", intr, dut.tcon[3]); end
      pulse_reti();
      n_cmp++; if (intr !== 1'b1 || int_vec !== 8'h13) begin n_err++; $display("FAIL lvl_rereq: got %b/%h want 1/13", intr, int_vec); end
      pulse_ack();
      int1_n = 1'b1;
      rd_addr = 8'h88;
      cyc(); cyc(); cyc();
      n_cmp++; if (dut.tcon[3] !== 1'b0) begin n_err++; $display("FAIL lvl_release: got %b want 0", dut.tcon[3]); end
      cyc();
      n_cmp++; if (data_out !== 8'h00 || intr !== 1'b0) begin n_err++; $display("FAIL lvl_idle: tcon %h intr %b want 00 0", data_out, intr); end
   endtask

   task automatic test_precedence();
      do_reset();
      rd_addr = 8'h88;
      tf1 = 1'b1;
      byte_wr(8'h88, 8'h00);
      tf1 = 1'b0;
      cyc();
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL sw_over_hw: got %h want 00", data_out); end
      tf1 = 1'b1;
      cyc();
      tf1 = 1'b0;
      cyc();
      n_cmp++; if (data_out !== 8'h80) begin n_err++; $display("FAIL tf1_set: got %h want 80", data_out); end
      rd_addr = 8'hA8;
      byte_wr(8'hA8, 8'h55);
      n_cmp++; if (data_out !== 8'h55) begin n_err++; $display("FAIL bypass: got %h want 55", data_out); end
      cyc();
      n_cmp++; if (data_out !== 8'h15) begin n_err++; $display("FAIL ie_mask: got %h want 15", data_out); end
      rd_addr = 8'h90;
      cyc();
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL unmapped_rd: got %h want 00", data_out); end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      byte_wr(8'hA8, 8'h90);
      pulse_ack();
      n_cmp++; if (dut.isr !== 2'b00) begin n_err++; $display("FAIL idle_ack: isr %b want 00", dut.isr); end
      uart_int = 1'b1;
      cyc();
      n_cmp++; if (intr !== 1'b1 || int_vec !== 8'h23) begin n_err++; $display("FAIL b2b_req: got %b/%h want 1/23", intr, int_vec); end
      int_ack = 1'b1; reti = 1'b1;
      cyc();
      int_ack = 1'b0; reti = 1'b0;
      n_cmp++; if (intr !== 1'b0 || dut.isr !== 2'b01) begin n_err++; $display("FAIL b2b_ack: intr/isr %b/%b want 0/01", intr, dut.isr); end
      reti = 1'b1;
      cyc();
      reti = 1'b0;
      n = 0;
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL b2b_rereq: got %b want 1", intr); end
      bit_wr(8'h8E, 1'b1);
      n_cmp++; if (tr1 !== 1'b1) begin n_err++; $display("FAIL tr1_bitwr: got %b want 1", tr1); end
      uart_int = 1'b0;
   endtask

   task automatic test_reset_in_req();
      do_reset();
      rd_addr = 8'hA8;
      byte_wr(8'hA8, 8'h82);
      bit_wr(8'h8C, 1'b1);
      tf0 = 1'b1;
      cyc();
      tf0 = 1'b0;
      cyc();
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL rst_pre_intr: got %b want 1", intr); end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (intr !== 1'b0 || int_vec !== 8'h00 || tr0 !== 1'b0 || data_out !== 8'h00)
         begin n_err++; $display("FAIL rst_async: intr %b vec %h tr0 %b dout %h want 0 00 0 00", intr, int_vec, tr0, data_out); end
      cyc();
      rst = 1'b0;
      cyc(); cyc();
      n_cmp++; if (intr !== 1'b0 || dut.tcon !== 8'h00) begin n_err++; $display("FAIL rst_no_retain: intr %b tcon %h want 0 00", intr, dut.tcon); end
   endtask

   initial begin
      test_reset();
      test_edge_int0();
      test_timer();
      test_priority();
      test_preempt();
      test_level();
      test_precedence();
      test_back_to_back();
      test_reset_in_req();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule

// File: doc/oc8051_irq_ctrl.md
# oc8051_irq_ctrl

Interrupt controller and TCON owner for the oc8051 core. It drives the timer/counter block from the other side: it holds TR0/TR1 and feeds them to the timer, and it captures the timer's tf0/tf1 overflow outputs as the TCON.TF flags. It also latches external INT0/INT1 and the serial-port request, arbitrates them through IE/IP across two priority levels, and presents one request plus its vector to the core decoder.

## Interface
- No parameters. SFR addresses, reset values and vectors come from `oc8051_defines.v`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_addr` in 8: write address. A byte address when `wr_bit`=0, a bit address when `wr_bit`=1.
- `rd_addr` in 8: byte read address.
- `data_in` in 8: byte write data.
- `bit_in` in 1: bit write data.
- `wr` in 1: write strobe.
- `wr_bit` in 1: bit-write qualifier.
- `int0_n`, `int1_n` in 1: external interrupt pins, asynchronous.
- `tf0`, `tf1` in 1: overflow outputs from the timer/counter block.
- `uart_int` in 1: serial request, level (RI|TI).
- `int_ack` in 1: one-cycle pulse; the core is taking the vector now.
- `reti` in 1: one-cycle pulse; RETI executed.
- `intr` out 1: interrupt request.
- `int_vec` out 8: vector address, valid while `intr`=1.
- `tr0`, `tr1` out 1: TCON.TR0/TR1, routed to the timer.
- `data_out` out 8: registered read data.

## Operation
- **Registers:**
  - IE (0xA8): EA=7, ES=4, ET1=3, EX1=2, ET0=1, EX0=0.
  - IP (0xB8): PS=4, PT1=3, PX1=2, PT0=1, PX0=0.
  - TCON (0x88): TF1=7, TR1=6, TF0=5, TR0=4, IE1=3, IT1=2, IE0=1, IT0=0.
  - All three are byte-writable. All three are bit-writable at address+bit (e.g. 0x8C=TR0).
  - Unimplemented IE/IP bits (6, 5) write-ignored, read 0.
- **Pin synchronisers:** `int0_n`/`int1_n` pass through a 2-flop synchroniser, then a third flop for edge detection.
- **IE0/IE1 flags:**
  - IT=1: a synchronised falling edge sets the flag; hardware clears it on ack of its vector.
  - IT=0: the flag equals the inverted synchronised pin every cycle; ack does not clear it.
- **TF0/TF1 flags:** set on a rising edge of `tf0`/`tf1`, i.e. input high while its 1-cycle-delayed copy is low. Hardware clears on ack of the vector.
- **Serial source:** not latched; request = `uart_int`.
- **Precedence per flag bit:** software write > hardware set > ack clear.
- **Pending mask:** `pend[i] = flag[i] & IE.en[i] & EA`.
- **Arbitration:**
  - The highest IP level among pending sources wins.
  - Within a level, fixed order IE0 > TF0 > IE1 > TF1 > SER.
  - Vectors: 0x03, 0x0B, 0x13, 0x1B, 0x23.
- **In-service register** `isr[1:0]` (bit1 = high level, bit0 = low level):
  - A winner is eligible only if its level exceeds the active level: none < low < high.
  - A low-level source cannot preempt a low-level handler.
  - A high-level source preempts a low-level handler; nothing preempts a high-level handler.
- **Request FSM** (2 states):
  - IDLE: when an eligible winner exists, register `intr`=1 and `int_vec` and move to REQ.
  - REQ: re-arbitrate every cycle, so `int_vec` tracks the current winner. If no eligible winner remains, drop `intr` and return to IDLE.
  - `int_ack` in REQ: set the winner's `isr` bit, clear its flag (per the rules above), drop `intr` next cycle, return to IDLE.
  - `int_ack` in IDLE: ignored.
- **reti:** clears the highest set `isr` bit. With `isr`=0 it has no effect.
- **Reads:**
  - `data_out` is updated every cycle from `rd_addr`: IE, IP, TCON; any other address returns 0.
  - Write-through bypass: a byte write to the same address as `rd_addr` in the same cycle returns `data_in`.

## Timing
- **Reset values:** IE=0, IP=0, TCON=0, `tr0`=`tr1`=0, `intr`=0, `int_vec`=0x00, `data_out`=0x00, `isr`=0, synchroniser flops = 1 (pins idle high).
- **Latencies:**
  - Pin edge to IE flag: 3 cycles.
  - `tf` rising edge to TF flag: 1 cycle.
  - Flag set to `intr`: 1 cycle.
  - `int_ack` to `intr` low: 1 cycle.
  - Earliest re-request after ack: 2 cycles.
- **Mid-operation changes:**
  - Clearing EA or the source enable while in REQ drops `intr` the next cycle.
  - `reti` and a new eligible request in the same cycle: `isr` updates first, so the request is evaluated against the new level in that cycle.
- **Simultaneous events on one flag:**
  - Edge arriving in the same cycle as an ack of that source: the flag stays 1.
  - `int_ack` and `reti` in the same cycle: set-then-clear on distinct bits are both applied.
- **Reset during REQ:** `intr` falls asynchronously and no state is retained.

## Structure
- `oc8051_defines.v` gains `OC8051_SFR_IE`, `OC8051_SFR_IP`, `OC8051_SFR_TCON`, the `OC8051_RST_*` values for each, the five `OC8051_INT_VEC_*` constants, and the source index order.
- One sub-module, `oc8051_int_sync`: the synchroniser plus falling-edge detector, instantiated twice.
- Arbitration is combinational inside the top block; flags, `isr` and the FSM are registered there.

## Test plan
- **Edge INT0:** IT0=1, EX0=1, EA=1; pulse `int0_n` low for 2 cycles -> `intr`=1 with `int_vec`=0x03 three or four cycles later; ack -> IE0=0, `isr`=01.
- **Timer overflow and TR bits:**
  - `tf0` high 1 cycle with ET0=1 -> `int_vec`=0x0B.
  - Bit-write 0x8C=1 -> `tr0`=1 the next cycle.
  - Read 0x88 -> 0x30 while TF0 and TR0 are both set.
- **Same-level priority:** IE0 and TF1 pending at once, IP=0 -> `int_vec`=0x03. After ack and `reti` -> 0x1B.
- **Preemption:**
  - In service of TF0 (low level), raise `uart_int` with PS=1 -> `intr`=1, vector 0x23, `isr`=11.
  - IE1 low-level -> no `intr` until two `reti` pulses.
- **Level mode:** IT1=0, hold `int1_n` low -> vector 0x13 reasserts after ack and `reti`; release the pin -> IE1=0 within 3 cycles.
- **Precedence and reset:**
  - Byte write TCON=0x00 in the same cycle as a `tf1` rising edge -> TF1=0.
  - Assert `rst` while `intr`=1 -> all outputs at reset values immediately.
